// File: rtl/msx_mem_arbiter_pkg.sv
// Shared types and default widths for the MSX external-memory arbiter.
package msx_mem_arbiter_pkg;

    localparam int unsigned MSX_AW = 27;
    localparam int unsigned MSX_DW = 8;

    typedef enum logic [2:0] {
        MAPPER_NONE,
        MAPPER_ASCII8,
        MAPPER_ASCII16,
        MAPPER_KONAMI,
        MAPPER_KONAMI_SCC
    } mapper_typ_t;

    typedef enum logic {
        GRANT_CPU = 1'b0,
        GRANT_DL  = 1'b1
    } grant_t;

    typedef enum logic {
        ARB_IDLE   = 1'b0,
        ARB_ACCESS = 1'b1
    } arb_state_t;

endpackage

// File: rtl/msx_mem_arbiter_arb_rr2.sv
// Two-way picker between CPU and download requests: fixed download priority
// or round-robin against the last granted requester.
module arb_rr2
    import msx_mem_arbiter_pkg::*;
(
    input  logic   clk,
    input  logic   reset,
    input  logic   req_cpu,
    input  logic   req_dl,
    input  logic   dl_priority,
    input  logic   take,
    output logic   valid_c,
    output grant_t grant_c
);

    grant_t last_grant_q;
    grant_t last_grant_d;

    always_comb begin
        valid_c = req_cpu | req_dl;
        grant_c = GRANT_CPU;
        if (req_cpu && req_dl) begin
            if (dl_priority) begin
                grant_c = GRANT_DL;
            end else begin
                grant_c = (last_grant_q == GRANT_DL) ? GRANT_CPU : GRANT_DL;
            end
        end else if (req_dl) begin
            grant_c = GRANT_DL;
        end
    end

    always_comb begin
        last_grant_d = last_grant_q;
        if (take && valid_c) begin
            last_grant_d = grant_c;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            last_grant_q <= GRANT_DL;
        end else begin
            last_grant_q <= last_grant_d;
        end
    end

endmodule

// File: rtl/msx_mem_arbiter.sv
// Shares one level-request / pulse-ack memory port between the CPU mapper
// request and a one-deep buffered HPS download write stream.
module msx_mem_arbiter
    import msx_mem_arbiter_pkg::*;
#(
    parameter int unsigned AW          = MSX_AW,
    parameter int unsigned DW          = MSX_DW,
    parameter bit          DL_PRIORITY = 1'b0
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          cpu_ram_cs,
    input  logic [AW-1:0] cpu_mem_addr,
    input  logic          cpu_mem_rnw,
    input  logic [DW-1:0] cpu_wdata,
    output logic [DW-1:0] cpu_rdata,
    output logic          cpu_wait,
    input  logic          dl_wr,
    input  logic [AW-1:0] dl_addr,
    input  logic [DW-1:0] dl_data,
    output logic          dl_wait,
    output logic          dl_overflow,
    output logic          mem_req,
    output logic [AW-1:0] mem_addr,
    output logic          mem_rnw,
    output logic [DW-1:0] mem_din,
    input  logic [DW-1:0] mem_dout,
    input  logic          mem_ack
);

    arb_state_t    state_q, state_d;
    grant_t        grant_q, grant_d;
    logic          mem_req_q, mem_req_d;
    logic [AW-1:0] mem_addr_q, mem_addr_d;
    logic          mem_rnw_q, mem_rnw_d;
    logic [DW-1:0] mem_din_q, mem_din_d;
    logic [DW-1:0] cpu_rdata_q, cpu_rdata_d;
    logic          served_q, served_d;
    logic          abandon_q, abandon_d;
    logic          dl_pend_q, dl_pend_d;
    logic [AW-1:0] dl_addr_q, dl_addr_d;
    logic [DW-1:0] dl_data_q, dl_data_d;
    logic          dl_overflow_q, dl_overflow_d;

    logic          cpu_busy_c;
    logic          cpu_pend_c;
    logic          ack_c;
    logic          dl_ack_c;
    logic          arb_valid_c;
    logic          arb_take_c;
    grant_t        arb_grant_c;

    assign cpu_busy_c = (state_q == ARB_ACCESS) && (grant_q == GRANT_CPU);
    assign cpu_pend_c = cpu_ram_cs && !served_q && !cpu_busy_c;
    assign ack_c      = (state_q == ARB_ACCESS) && mem_ack;
    assign dl_ack_c   = ack_c && (grant_q == GRANT_DL);
    assign arb_take_c = (state_q == ARB_IDLE) && arb_valid_c;

    arb_rr2 u_arb (
        .clk         (clk),
        .reset       (reset),
        .req_cpu     (cpu_pend_c),
        .req_dl      (dl_pend_q),
        .dl_priority (DL_PRIORITY),
        .take        (arb_take_c),
        .valid_c     (arb_valid_c),
        .grant_c     (arb_grant_c)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ARB_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ARB_IDLE:   if (arb_take_c) state_d = ARB_ACCESS;
            ARB_ACCESS: if (mem_ack)    state_d = ARB_IDLE;
            default:                    state_d = ARB_IDLE;
        endcase
    end

    always_comb begin
        grant_d       = grant_q;
        mem_req_d     = mem_req_q;
        mem_addr_d    = mem_addr_q;
        mem_rnw_d     = mem_rnw_q;
        mem_din_d     = mem_din_q;
        cpu_rdata_d   = cpu_rdata_q;
        served_d      = served_q;
        abandon_d     = abandon_q;
        dl_pend_d     = dl_pend_q;
        dl_addr_d     = dl_addr_q;
        dl_data_d     = dl_data_q;
        dl_overflow_d = dl_overflow_q;

        if (arb_take_c) begin
            mem_req_d = 1'b1;
            grant_d   = arb_grant_c;
            abandon_d = 1'b0;
            if (arb_grant_c == GRANT_DL) begin
                mem_addr_d = dl_addr_q;
                mem_rnw_d  = 1'b0;
                mem_din_d  = dl_data_q;
            end else begin
                mem_addr_d = cpu_mem_addr;
                mem_rnw_d  = cpu_mem_rnw;
                mem_din_d  = cpu_wdata;
            end
        end

        // A CPU cycle that ends before its ack must not be marked served.
        if (cpu_busy_c && !cpu_ram_cs) begin
            abandon_d = 1'b1;
        end

        if (ack_c) begin
            mem_req_d = 1'b0;
            if (grant_q == GRANT_CPU && mem_rnw_q) begin
                cpu_rdata_d = mem_dout;
            end
            if (grant_q == GRANT_DL) begin
                dl_pend_d = 1'b0;
            end
        end

        if (!cpu_ram_cs) begin
            served_d = 1'b0;
        end else if (ack_c && grant_q == GRANT_CPU && !abandon_q) begin
            served_d = 1'b1;
        end

        // The slot freed by this cycle's download ack can take a new write.
        if (dl_wr) begin
            if (!dl_pend_q || dl_ack_c) begin
                dl_pend_d = 1'b1;
                dl_addr_d = dl_addr;
                dl_data_d = dl_data;
            end else begin
                dl_overflow_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            grant_q       <= GRANT_CPU;
            mem_req_q     <= 1'b0;
            mem_addr_q    <= '1;
            mem_rnw_q     <= 1'b1;
            mem_din_q     <= '1;
            cpu_rdata_q   <= '1;
            served_q      <= 1'b0;
            abandon_q     <= 1'b0;
            dl_pend_q     <= 1'b0;
            dl_addr_q     <= '0;
            dl_data_q     <= '0;
            dl_overflow_q <= 1'b0;
        end else begin
            grant_q       <= grant_d;
            mem_req_q     <= mem_req_d;
            mem_addr_q    <= mem_addr_d;
            mem_rnw_q     <= mem_rnw_d;
            mem_din_q     <= mem_din_d;
            cpu_rdata_q   <= cpu_rdata_d;
            served_q      <= served_d;
            abandon_q     <= abandon_d;
            dl_pend_q     <= dl_pend_d;
            dl_addr_q     <= dl_addr_d;
            dl_data_q     <= dl_data_d;
            dl_overflow_q <= dl_overflow_d;
        end
    end

    assign cpu_wait    = cpu_ram_cs && !served_q;
    assign cpu_rdata   = cpu_rdata_q;
    assign dl_wait     = dl_pend_q;
    assign dl_overflow = dl_overflow_q;
    assign mem_req     = mem_req_q;
    assign mem_addr    = mem_addr_q;
    assign mem_rnw     = mem_rnw_q;
    assign mem_din     = mem_din_q;

endmodule

// File: tb/tb_msx_mem_arbiter.sv
// Scoreboard bench for msx_mem_arbiter: round-robin instance fully checked,
// a download-priority instance checked for grant order.
module tb_msx_mem_arbiter;

    typedef struct {
        logic [26:0] addr;
        logic        rnw;
        logic [7:0]  din;
    } acc_t;

    logic        clk;
    logic        reset;
    logic        cpu_ram_cs;
    logic [26:0] cpu_mem_addr;
    logic        cpu_mem_rnw;
    logic [7:0]  cpu_wdata;
    logic        dl_wr;
    logic [26:0] dl_addr;
    logic [7:0]  dl_data;

    logic [7:0]  cpu_rdata;
    logic        cpu_wait, dl_wait, dl_overflow;
    logic        mem_req, mem_rnw, mem_ack;
    logic [26:0] mem_addr;
    logic [7:0]  mem_din, mem_dout;

    logic [7:0]  cpu_rdata1;
    logic        cpu_wait1, dl_wait1, dl_overflow1;
    logic        mem_req1, mem_rnw1, mem_ack1;
    logic [26:0] mem_addr1;
    logic [7:0]  mem_din1, mem_dout1;

    logic        resp_ack, force_ack;
    logic [7:0]  resp_dout, force_dout;
    logic        resp_en;
    int          resp_dly;
    int          resp_d;

    acc_t        mem_q[$];
    logic [7:0]  rd_q[$];
    logic [26:0] got1[$];
    logic [7:0]  ref_mem[logic [26:0]];
    logic [7:0]  mem_model[logic [26:0]];
    logic [7:0]  exp_rdata;

    int          n_chk, n_pass;
    int          req_rises;

    acc_t        mon_e;
    logic        prev_req, prev_cw, stable, prev1;
    logic [26:0] lat_addr;
    logic        lat_rnw;
    logic [7:0]  lat_din;

    assign mem_ack  = resp_ack | force_ack;
    assign mem_dout = force_ack ? force_dout : resp_dout;

    msx_mem_arbiter #(.DL_PRIORITY(1'b0)) dut (
        .clk(clk), .reset(reset),
        .cpu_ram_cs(cpu_ram_cs), .cpu_mem_addr(cpu_mem_addr), .cpu_mem_rnw(cpu_mem_rnw),
        .cpu_wdata(cpu_wdata), .cpu_rdata(cpu_rdata), .cpu_wait(cpu_wait),
        .dl_wr(dl_wr), .dl_addr(dl_addr), .dl_data(dl_data),
        .dl_wait(dl_wait), .dl_overflow(dl_overflow),
        .mem_req(mem_req), .mem_addr(mem_addr), .mem_rnw(mem_rnw), .mem_din(mem_din),
        .mem_dout(mem_dout), .mem_ack(mem_ack)
    );

    msx_mem_arbiter #(.DL_PRIORITY(1'b1)) dut_prio (
        .clk(clk), .reset(reset),
        .cpu_ram_cs(cpu_ram_cs), .cpu_mem_addr(cpu_mem_addr), .cpu_mem_rnw(cpu_mem_rnw),
        .cpu_wdata(cpu_wdata), .cpu_rdata(cpu_rdata1), .cpu_wait(cpu_wait1),
        .dl_wr(dl_wr), .dl_addr(dl_addr), .dl_data(dl_data),
        .dl_wait(dl_wait1), .dl_overflow(dl_overflow1),
        .mem_req(mem_req1), .mem_addr(mem_addr1), .mem_rnw(mem_rnw1), .mem_din(mem_din1),
        .mem_dout(mem_dout1), .mem_ack(mem_ack1)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic logic [7:0] dflt(input logic [26:0] a);
        return a[7:0] ^ 8'hA5;
    endfunction

    function automatic logic [7:0] ref_rd(input logic [26:0] a);
        return ref_mem.exists(a) ? ref_mem[a] : dflt(a);
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    endtask

    // Memory model behind the round-robin instance: ack resp_dly cycles after req.
    initial begin
        resp_ack  = 1'b0;
        resp_dout = 8'h00;
        mem_model[27'h0001234] = 8'h5A;
        forever begin
            @(negedge clk);
            if (resp_en && mem_req && !reset) begin
                resp_d = resp_dly;
                repeat (resp_d) @(negedge clk);
                if (mem_req) begin
                    resp_ack = 1'b1;
                    if (!mem_rnw) mem_model[mem_addr] = mem_din;
                    else resp_dout = mem_model.exists(mem_addr) ? mem_model[mem_addr] : dflt(mem_addr);
                    @(negedge clk);
                    resp_ack = 1'b0;
                end
            end
        end
    end

    // Priority instance: fixed one-cycle ack, grant addresses recorded in order.
    initial begin
        mem_ack1  = 1'b0;
        mem_dout1 = 8'h00;
        forever begin
            @(negedge clk);
            if (mem_req1 && !reset) begin
                @(negedge clk);
                mem_ack1 = 1'b1;
                @(negedge clk);
                mem_ack1 = 1'b0;
            end
        end
    end

    initial begin
        prev1 = 1'b0;
        forever begin
            @(posedge clk); #2;
            if (mem_req1 && !prev1) got1.push_back(mem_addr1);
            prev1 = mem_req1;
        end
    end

    // Monitor: memory requests and CPU read data against the scoreboard queues.
    initial begin
        prev_req = 1'b0; prev_cw = 1'b0; stable = 1'b1;
        forever begin
            @(posedge clk); #2;
            if (mem_req && !prev_req) begin
                req_rises++;
                if (mem_q.size() == 0) begin
                    n_chk++;
                    $display("FAIL unexpected_req: addr %0h rnw %0b with nothing expected", mem_addr, mem_rnw);
                end else begin
                    mon_e = mem_q.pop_front();
                    chk("req_addr", 32'(mem_addr), 32'(mon_e.addr));
                    chk("req_rnw", 32'(mem_rnw), 32'(mon_e.rnw));
                    if (!mon_e.rnw) chk("req_din", 32'(mem_din), 32'(mon_e.din));
                end
                lat_addr = mem_addr; lat_rnw = mem_rnw; lat_din = mem_din; stable = 1'b1;
            end else if (mem_req && prev_req) begin
                if (mem_addr !== lat_addr || mem_rnw !== lat_rnw || mem_din !== lat_din) stable = 1'b0;
            end else if (!mem_req && prev_req) begin
                chk("req_hold_stable", 32'(stable), 32'd1);
            end
            if (prev_cw && cpu_ram_cs && !cpu_wait) begin
                if (rd_q.size() == 0) begin
                    n_chk++;
                    $display("FAIL unexpected_cpu_done: rdata %0h with nothing expected", cpu_rdata);
                end else begin
                    chk("cpu_rdata", 32'(cpu_rdata), 32'(rd_q.pop_front()));
                end
            end
            prev_req = mem_req;
            prev_cw  = cpu_ram_cs && cpu_wait;
        end
    end

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1; cpu_ram_cs = 1'b0; dl_wr = 1'b0;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        exp_rdata = 8'hFF;
    endtask

    task automatic wait_cpu_done(output int n);
        n = 0;
        forever begin
            @(posedge clk); #2;
            if (!cpu_wait || n > 200) break;
            n++;
        end
    endtask

    task automatic wait_dl_idle();
        int n;
        n = 0;
        while (dl_wait && n < 200) begin
            @(posedge clk); #2;
            n++;
        end
        chk("dl_drain", 32'(dl_wait), 32'd0);
    endtask

    task automatic push_acc(input logic [26:0] a, input logic rnw, input logic [7:0] d);
        acc_t e;
        e.addr = a; e.rnw = rnw; e.din = d;
        mem_q.push_back(e);
    endtask

    task automatic cpu_access(input logic [26:0] a, input logic rnw, input logic [7:0] wd,
                              input int dly, input int hold);
        int n, r0;
        resp_dly = dly;
        @(negedge clk);
        cpu_ram_cs = 1'b1; cpu_mem_addr = a; cpu_mem_rnw = rnw; cpu_wdata = wd;
        push_acc(a, rnw, wd);
        if (rnw) exp_rdata = ref_rd(a);
        else ref_mem[a] = wd;
        rd_q.push_back(exp_rdata);
        r0 = req_rises;
        #1 chk("cpu_wait_cs_cycle", 32'(cpu_wait), 32'd1);
        wait_cpu_done(n);
        chk("cpu_wait_cycles", 32'(n), 32'(dly + 1));
        repeat (hold) @(posedge clk);
        @(negedge clk);
        cpu_ram_cs = 1'b0;
        chk("one_req_per_cs", 32'(req_rises - r0), 32'd1);
    endtask

    task automatic dl_write(input logic [26:0] a, input logic [7:0] d, input int dly);
        resp_dly = dly;
        @(negedge clk);
        dl_wr = 1'b1; dl_addr = a; dl_data = d;
        push_acc(a, 1'b0, d);
        ref_mem[a] = d;
        @(negedge clk);
        dl_wr = 1'b0;
        chk("dl_wait_set", 32'(dl_wait), 32'd1);
        wait_dl_idle();
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int n, b1, hi;
        logic [26:0] a;
        logic [7:0]  d;
        n_chk = 0; n_pass = 0; req_rises = 0;
        reset = 1'b1; cpu_ram_cs = 1'b0; cpu_mem_addr = '0; cpu_mem_rnw = 1'b1; cpu_wdata = '0;
        dl_wr = 1'b0; dl_addr = '0; dl_data = '0;
        force_ack = 1'b0; force_dout = 8'h00; resp_en = 1'b1; resp_dly = 0;
        exp_rdata = 8'hFF;
        ref_mem[27'h0001234] = 8'h5A;

        // Reset state
        do_reset();
        chk("rst_mem_req", 32'(mem_req), 32'd0);
        chk("rst_mem_rnw", 32'(mem_rnw), 32'd1);
        chk("rst_mem_addr", 32'(mem_addr), 32'h07FF_FFFF);
        chk("rst_mem_din", 32'(mem_din), 32'hFF);
        chk("rst_cpu_rdata", 32'(cpu_rdata), 32'hFF);
        chk("rst_dl_wait", 32'(dl_wait), 32'd0);
        chk("rst_dl_overflow", 32'(dl_overflow), 32'd0);
        chk("rst_cpu_wait", 32'(cpu_wait), 32'd0);

        // CPU read, slow ack, cs held long after completion
        cpu_access(27'h0001234, 1'b1, 8'h00, 3, 6);
        chk("read_5a", 32'(cpu_rdata), 32'h5A);

        // CPU write leaves read data alone
        cpu_access(27'h0004000, 1'b0, 8'hC3, 2, 0);
        chk("write_keeps_rdata", 32'(cpu_rdata), 32'h5A);

        // Both pending after reset: round-robin grants CPU first, priority grants DL first
        do_reset();
        b1 = got1.size();
        resp_dly = 2;
        @(negedge clk);
        dl_wr = 1'b1; dl_addr = 27'h0300010; dl_data = 8'h3C;
        @(negedge clk);
        dl_wr = 1'b0;
        cpu_ram_cs = 1'b1; cpu_mem_addr = 27'h0200020; cpu_mem_rnw = 1'b1;
        push_acc(27'h0200020, 1'b1, 8'h00);
        push_acc(27'h0300010, 1'b0, 8'h3C);
        exp_rdata = ref_rd(27'h0200020);
        rd_q.push_back(exp_rdata);
        ref_mem[27'h0300010] = 8'h3C;
        wait_cpu_done(n);
        chk("rr_cpu_done", 32'(cpu_wait), 32'd0);
        wait_dl_idle();
        n = 0;
        while (cpu_wait1 && n < 200) begin
            @(posedge clk); #2;
            n++;
        end
        chk("prio_cpu_done", 32'(cpu_wait1), 32'd0);
        @(negedge clk);
        cpu_ram_cs = 1'b0;
        chk("prio_grant_count", 32'(got1.size() - b1), 32'd2);
        if (got1.size() >= b1 + 2) begin
            chk("prio_first_dl", 32'(got1[b1]), 32'h0300010);
            chk("prio_second_cpu", 32'(got1[b1 + 1]), 32'h0200020);
        end

        // Back-to-back download strobes: second dropped, overflow sticky until reset
        resp_dly = 5;
        @(negedge clk);
        dl_wr = 1'b1; dl_addr = 27'h0000100; dl_data = 8'h11;
        push_acc(27'h0000100, 1'b0, 8'h11);
        ref_mem[27'h0000100] = 8'h11;
        @(negedge clk);
        dl_addr = 27'h0000101; dl_data = 8'h22;
        @(negedge clk);
        dl_wr = 1'b0;
        chk("ovf_dl_wait", 32'(dl_wait), 32'd1);
        chk("ovf_set", 32'(dl_overflow), 32'd1);
        wait_dl_idle();
        repeat (3) @(posedge clk);
        chk("ovf_sticky", 32'(dl_overflow), 32'd1);
        do_reset();
        chk("ovf_cleared_by_reset", 32'(dl_overflow), 32'd0);

        // Download write landing on the same cycle as the download ack is accepted
        resp_dly = 3;
        @(negedge clk);
        dl_wr = 1'b1; dl_addr = 27'h0000200; dl_data = 8'h44;
        push_acc(27'h0000200, 1'b0, 8'h44);
        ref_mem[27'h0000200] = 8'h44;
        @(negedge clk);
        dl_wr = 1'b0;
        n = 0;
        while (!mem_req && n < 50) begin
            @(negedge clk);
            n++;
        end
        chk("ack_race_req_seen", 32'(mem_req), 32'd1);
        repeat (3) @(negedge clk);
        dl_wr = 1'b1; dl_addr = 27'h0000201; dl_data = 8'h55;
        push_acc(27'h0000201, 1'b0, 8'h55);
        ref_mem[27'h0000201] = 8'h55;
        @(negedge clk);
        dl_wr = 1'b0;
        chk("ack_race_accepted", 32'(dl_wait), 32'd1);
        chk("ack_race_no_ovf", 32'(dl_overflow), 32'd0);
        wait_dl_idle();
        chk("ack_race_no_ovf_end", 32'(dl_overflow), 32'd0);

        // Randomized serial traffic against the reference memory
        for (int i = 0; i < 40; i++) begin
            a = 27'(($urandom_range(0, 3) << 24) | $urandom_range(0, 7));
            d = 8'($urandom);
            case ($urandom_range(0, 2))
                0:       cpu_access(a, 1'b1, 8'h00, int'($urandom_range(0, 4)), int'($urandom_range(0, 2)));
                1:       cpu_access(a, 1'b0, d, int'($urandom_range(0, 4)), int'($urandom_range(0, 2)));
                default: dl_write(a, d, int'($urandom_range(0, 4)));
            endcase
        end

        // Reset during an access: request dropped, buffered download lost, late ack ignored
        resp_en = 1'b0;
        @(negedge clk);
        cpu_ram_cs = 1'b1; cpu_mem_addr = 27'h0000777; cpu_mem_rnw = 1'b1;
        dl_wr = 1'b1; dl_addr = 27'h0000888; dl_data = 8'h99;
        push_acc(27'h0000777, 1'b1, 8'h00);
        @(negedge clk);
        dl_wr = 1'b0;
        chk("rst_mid_req_up", 32'(mem_req), 32'd1);
        chk("rst_mid_dl_pend", 32'(dl_wait), 32'd1);
        reset = 1'b1;
        @(negedge clk);
        chk("rst_mid_req_drop", 32'(mem_req), 32'd0);
        chk("rst_mid_rdata", 32'(cpu_rdata), 32'hFF);
        chk("rst_mid_dl_lost", 32'(dl_wait), 32'd0);
        reset = 1'b0; cpu_ram_cs = 1'b0;
        exp_rdata = 8'hFF;
        force_dout = 8'h77; force_ack = 1'b1;
        @(negedge clk);
        force_ack = 1'b0;
        hi = 0;
        repeat (6) begin
            @(posedge clk); #2;
            if (mem_req) hi++;
        end
        chk("late_ack_no_req", 32'(hi), 32'd0);
        chk("late_ack_rdata", 32'(cpu_rdata), 32'hFF);
        resp_en = 1'b1;
        cpu_access(27'h0001234, 1'b1, 8'h00, 1, 1);

        repeat (4) @(posedge clk);
        chk("mem_q_drained", 32'(mem_q.size()), 32'd0);
        chk("rd_q_drained", 32'(rd_q.size()), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
